serial_fa_ctrl: RTL
===================

// Module: serial_fa_ctrl
// PURPOSE
//   Sequencer that performs a WIDTH-bit add/subtract using one external 1-bit full
//   adder (FA, purely combinational). Operands are accepted on a start/done handshake,
//   fed LSB-first one bit per clock into the FA, and the carry is registered between
//   bits. Sits between a requesting host and a single shared FA instance.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//   clk       in   1      system clock, all state on rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled only when accepting (IDLE or DONE)
//   op_sub    in   1      0: a+b+cin   1: a-b (b inverted, carry-in forced 1, cin ignored)
//   a         in   WIDTH  operand A, captured on accepted start
//   b         in   WIDTH  operand B, captured on accepted start
//   cin       in   1      carry-in for add, captured on accepted start
//   fa_x      out  1      to FA X input
//   fa_y      out  1      to FA Y input
//   fa_cin    out  1      to FA Cin input
//   fa_sum    in   1      from FA Sum
//   fa_cout   in   1      from FA Cout
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle completion pulse
//   sum       out  WIDTH  registered result, held until next completion
//   cout      out  1      final carry (sub: 1 = no borrow)
//   ovf       out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy, done, sum, cout, ovf, fa_x/y/cin = 0;
//     internal shift regs, carry reg, bit counter = 0. Reset mid-RUN aborts; no done.
//   - FSM: IDLE -(start)-> RUN; RUN -(count==WIDTH-1 at edge)-> DONE;
//     DONE -(start)-> RUN, else -> IDLE. start ignored in RUN.
//   - Accept edge: a_sh<=a; b_sh<= op_sub ? ~b : b; carry<= op_sub ? 1 : cin; count<=0.
//   - In RUN (combinational): fa_x=a_sh[0], fa_y=b_sh[0], fa_cin=carry.
//     Outside RUN fa_x/fa_y/fa_cin = 0.
//   - Each RUN edge: res_sh <= {fa_sum, res_sh[WIDTH-1:1]}; a_sh,b_sh >>1;
//     carry<=fa_cout; count<=count+1. On last bit edge also capture cmsb<=carry.
//   - Edge leaving RUN: sum<={fa_sum,res_sh[WIDTH-1:1]}; cout<=fa_cout;
//     ovf<=carry^fa_cout (carry = carry into MSB). Outputs update only here.
//   - done=1 exactly in the DONE cycle, i.e. WIDTH edges after the accepting edge.
//     Throughput: back-to-back ops with start in DONE, period WIDTH+1 cycles.
//   - busy=1 for exactly WIDTH cycles per op; busy and done never both high.
//   - FA outputs assumed settled within one cycle; no FA-side handshake.
// TESTING
//   1. Reset mid-RUN (after 3 bits): all outputs 0, state IDLE; next start runs cleanly.
//   2. add 0x5A+0x3C cin=0 -> sum=0x96 cout=0 ovf=1; done exactly 8 cycles after accept.
//   3. add 0xFF+0x01 cin=0 -> sum=0x00 cout=1 ovf=0; 0xFF+0x00 cin=1 -> same.
//   4. sub 0x10-0x20 -> 0xF0 cout=0 ovf=0; sub 0x80-0x01 -> 0x7F cout=1 ovf=1.
//   5. start held high through RUN -> ignored; start in DONE -> busy next cycle, no gap.
//   6. 1000 random ops both modes vs a+b+cin / a-b model; check fa_* = 0 outside RUN.

Source files
------------

// File: rtl/serial_fa_ctrl.sv
// Bit-serial add/subtract sequencer driving one external combinational full adder.
// Operands are shifted LSB-first into the FA; the carry is registered between bits.
module serial_fa_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             in_run;

  // The FA sees operands only while a bit is actually being processed.
  assign in_run = (state == RUN);
  assign fa_x   = in_run & a_sh[0];
  assign fa_y   = in_run & b_sh[0];
  assign fa_cin = in_run & carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the add path is reused unchanged.
            state <= RUN;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= op_sub ? ~b : b;
            carry <= op_sub ? 1'b1 : cin;
            count <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          count  <= count + 1'b1;
          if (count == LAST) begin
            // carry still holds the carry into the MSB at this edge.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {fa_sum, res_sh[WIDTH-1:1]};
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
